// File: rtl/klp32_pkg.sv
// Shared types and constants for the KLP32 fetch front end.
package klp32_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;
    localparam logic [31:0] PC_STEP  = 32'd4;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with extra-bit pointers; flush beats push/pop, full may pop and push in one cycle.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    // NOTE: every signal driven here gets a value before any condition, so no latch can be inferred.
    always_comb begin
        count    = wr_ptr_q - rd_ptr_q;
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
        rdata = mem_q[rd_ptr_q[AW-1:0]];
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define which slots are valid.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/ifetch_queue.sv
// KLP32 stage-1 fetch: PC generation, credit-limited imem requests, wrong-path drop and a fetch buffer.
module ifetch_queue
    import klp32_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    input  logic        i_stall,
    output logic        o_imem_req_valid,
    output logic [31:0] o_imem_req_addr,
    input  logic        i_imem_req_ready,
    input  logic        i_imem_rsp_valid,
    input  logic [31:0] i_imem_rsp_data,
    output logic        o_fetch_valid,
    output logic [31:0] o_fetch_inst,
    output logic [31:0] o_fetch_pc,
    output logic [31:0] o_fetch_pc_inc
);

    localparam int             CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0]    DEPTH_L = DEPTH[CW:0];
    localparam logic [CW-1:0]  ONE     = {{(CW-1){1'b0}}, 1'b1};

    logic [31:0]   req_pc_q, req_pc_d;
    logic [31:0]   rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] drop_q, drop_d;

    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_flush;
    logic          push;
    logic          pop;
    logic          req_fire;
    logic          rsp_drop;
    logic [CW:0]   credit_used;
    logic [31:0]   target;
    fetch_entry_t  push_entry;
    fetch_entry_t  head;

    sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata (push_entry),
        .pop   (pop),
        .flush (fifo_flush),
        .rdata (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        target      = word_align(i_redirect_pc);
        // Buffered words plus words still in flight may never exceed the queue size.
        credit_used = {1'b0, fifo_count} + {1'b0, outstanding_q};

        o_imem_req_valid = !reset && !i_redirect && (credit_used < DEPTH_L);
        o_imem_req_addr  = req_pc_q;
        req_fire         = o_imem_req_valid && i_imem_req_ready;

        rsp_drop   = i_imem_rsp_valid && (drop_q != '0);
        push       = i_imem_rsp_valid && !rsp_drop;
        push_entry = '{inst: i_imem_rsp_data, pc: rsp_pc_q};
        fifo_flush = reset || i_redirect;

        o_fetch_valid = !fifo_empty;
        pop           = o_fetch_valid && !i_stall && !i_redirect;

        o_fetch_inst   = NOP_INST;
        o_fetch_pc     = '0;
        o_fetch_pc_inc = '0;
        if (o_fetch_valid) begin
            o_fetch_inst   = head.inst;
            o_fetch_pc     = head.pc;
            o_fetch_pc_inc = head.pc + PC_STEP;
        end
    end

    always_comb begin
        req_pc_d      = req_pc_q;
        rsp_pc_d      = rsp_pc_q;
        drop_d        = drop_q;
        outstanding_d = outstanding_q;

        if (req_fire) begin
            req_pc_d      = req_pc_q + PC_STEP;
            outstanding_d = outstanding_d + ONE;
        end
        if (i_imem_rsp_valid) begin
            outstanding_d = outstanding_d - ONE;
        end
        if (rsp_drop) begin
            drop_d = drop_q - ONE;
        end
        if (push) begin
            rsp_pc_d = rsp_pc_q + PC_STEP;
        end

        // Everything still in flight after this edge belongs to the old path.
        if (i_redirect) begin
            req_pc_d = target;
            rsp_pc_d = target;
            drop_d   = outstanding_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            req_pc_q      <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            req_pc_q      <= req_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(push && fifo_full && !pop));

    a_no_rsp_underflow: assert property (@(posedge clk) disable iff (reset)
        !(i_imem_rsp_valid && (outstanding_q == '0)));

endmodule
